// File: rtl/ppu_bus_pkg.sv
// Shared types and defaults for the PPU-side bus controller.
// Mirroring mode encodings and nametable geometry helpers live here.
package ppu_bus_pkg;

    localparam int NT_BITS_DEF      = 10;
    localparam int NT_COUNT_DEF     = 2;
    localparam int DECAY_CYCLES_DEF = 1_000_000;

    typedef enum logic [2:0] {
        MIR_H         = 3'd0,
        MIR_V         = 3'd1,
        MIR_SINGLE_LO = 3'd2,
        MIR_SINGLE_HI = 3'd3,
        MIR_CART      = 3'd4
    } mirror_e;

    // Bank bits needed to address every physical nametable.
    function automatic int bank_width(input int nt_count);
        return (nt_count > 2) ? 2 : 1;
    endfunction

    function automatic int vram_depth(input int nt_bits, input int nt_count);
        return nt_count * (1 << nt_bits);
    endfunction

endpackage

// File: rtl/ppu_bus_ctrl_if.sv
// PPU address/data port plus cartridge CIRAM signals seen by ppu_bus_ctrl.
// master = PPU/cartridge side, slave = the bus controller.
interface ppu_bus_ctrl_if;

    logic [13:0] addr;
    logic        rd;
    logic        wr;
    logic        vram_cs;
    logic [2:0]  mirror_i;
    logic        cart_a10;
    logic [7:0]  ppu_data_i;
    logic [7:0]  cart_data_i;
    logic [7:0]  data_o;
    logic        rvalid_o;

    modport master (
        output addr,
        output rd,
        output wr,
        output vram_cs,
        output mirror_i,
        output cart_a10,
        output ppu_data_i,
        output cart_data_i,
        input  data_o,
        input  rvalid_o
    );

    modport slave (
        input  addr,
        input  rd,
        input  wr,
        input  vram_cs,
        input  mirror_i,
        input  cart_a10,
        input  ppu_data_i,
        input  cart_data_i,
        output data_o,
        output rvalid_o
    );

endinterface

// File: rtl/ppu_nt_map.sv
// Combinational nametable mapper: PPU address + mirroring mode -> VRAM index.
// With four physical nametables the address bits select the bank directly.
module ppu_nt_map
    import ppu_bus_pkg::*;
#(
    parameter int NT_BITS  = NT_BITS_DEF,
    parameter int NT_COUNT = NT_COUNT_DEF
) (
    input  logic [13:0]                                 addr,
    input  logic [2:0]                                  mirror_i,
    input  logic                                        cart_a10,
    output logic [NT_BITS+bank_width(NT_COUNT)-1:0]     index
);

    mirror_e mode;
    logic    bank_two;
    logic    unused_addr;

    assign mode        = mirror_e'(mirror_i);
    assign unused_addr = ^addr[13:12];

    // Reserved modes 5-7 fall back to vertical mirroring.
    always_comb begin
        bank_two = addr[10];
        case (mode)
            MIR_H:         bank_two = addr[11];
            MIR_V:         bank_two = addr[10];
            MIR_SINGLE_LO: bank_two = 1'b0;
            MIR_SINGLE_HI: bank_two = 1'b1;
            MIR_CART:      bank_two = cart_a10;
            default:       bank_two = addr[10];
        endcase
    end

    generate
        if (NT_COUNT == 4) begin : g_four
            logic unused_sel;
            assign unused_sel = bank_two;
            assign index      = {addr[11:10], addr[NT_BITS-1:0]};
        end else begin : g_two
            assign index = {bank_two, addr[NT_BITS-1:0]};
        end
    endgenerate

endmodule

// File: rtl/ppu_bus_ctrl.sv
// PPU bus controller: nametable VRAM, open-bus data latch and 1-cycle read path.
// Define PPU_BUS_DECAY_EN to build the idle counter that clears the open-bus latch.
module ppu_bus_ctrl
    import ppu_bus_pkg::*;
#(
    parameter int NT_BITS      = NT_BITS_DEF,
    parameter int NT_COUNT     = NT_COUNT_DEF,
    parameter int DECAY_CYCLES = DECAY_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           rst,
    ppu_bus_ctrl_if.slave  bus
);

    localparam int BANK_W = bank_width(NT_COUNT);
    localparam int IDX_W  = NT_BITS + BANK_W;
    localparam int DEPTH  = vram_depth(NT_BITS, NT_COUNT);

    logic [7:0]       vram [DEPTH];
    logic [IDX_W-1:0] idx;
    logic [7:0]       rd_data;
    logic [7:0]       latch;
    logic             rvalid;
    logic             do_wr;
    logic             do_rd;
    logic             decay_hit;

    // A simultaneous rd+wr is a plain write.
    assign do_wr = bus.wr;
    assign do_rd = bus.rd & ~bus.wr;

    ppu_nt_map #(
        .NT_BITS  (NT_BITS),
        .NT_COUNT (NT_COUNT)
    ) u_nt_map (
        .addr     (bus.addr),
        .mirror_i (bus.mirror_i),
        .cart_a10 (bus.cart_a10),
        .index    (idx)
    );

    // VRAM is never cleared; a write landing on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && do_wr && bus.vram_cs) begin
            vram[idx] <= bus.ppu_data_i;
        end
    end

    assign rd_data = bus.vram_cs ? vram[idx] : bus.cart_data_i;

`ifdef PPU_BUS_DECAY_EN
    localparam int                CNT_W   = $clog2(DECAY_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DECAY_CYCLES);

    logic [CNT_W-1:0] decay_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt <= '0;
        end else if (bus.rd || bus.wr) begin
            decay_cnt <= '0;
        end else if (decay_cnt != CNT_MAX) begin
            decay_cnt <= decay_cnt + 1'b1;
        end
    end

    // Clear on the edge where the counter lands on its saturation value.
    assign decay_hit = !(bus.rd || bus.wr) && (decay_cnt == CNT_MAX - 1'b1);
`else
    assign decay_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            latch  <= 8'h00;
            rvalid <= 1'b0;
        end else begin
            rvalid <= do_rd;
            if (do_wr) begin
                latch <= bus.ppu_data_i;
            end else if (do_rd) begin
                latch <= rd_data;
            end else if (decay_hit) begin
                latch <= 8'h00;
            end
        end
    end

    assign bus.data_o   = latch;
    assign bus.rvalid_o = rvalid;

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Directed, table-driven bench for ppu_bus_ctrl (two- and four-nametable builds).
// Honours PPU_BUS_DECAY_EN for the open-bus decay sequence.
module tb_ppu_bus_ctrl;
    import ppu_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    ppu_bus_ctrl_if bus2 ();
    ppu_bus_ctrl_if bus4 ();

    ppu_bus_ctrl #(.NT_BITS(10), .NT_COUNT(2), .DECAY_CYCLES(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    ppu_bus_ctrl #(.NT_BITS(10), .NT_COUNT(4), .DECAY_CYCLES(16)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic        cs;
        logic [2:0]  mir;
        logic        a10;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  cdata;
        logic [7:0]  exp_d;
        logic        exp_v;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic cs, input logic [2:0] mir, input logic a10,
                                input logic [13:0] addr, input logic [7:0] wdata,
                                input logic [7:0] cdata, input logic [7:0] exp_d,
                                input logic exp_v);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.cs = cs; v.mir = mir; v.a10 = a10;
        v.addr = addr; v.wdata = wdata; v.cdata = cdata; v.exp_d = exp_d; v.exp_v = exp_v;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic idle2();
        bus2.rd = 1'b0;
        bus2.wr = 1'b0;
    endtask

    task automatic apply2(input vec_t v);
        bus2.rd          = v.rd;
        bus2.wr          = v.wr;
        bus2.vram_cs     = v.cs;
        bus2.mirror_i    = v.mir;
        bus2.cart_a10    = v.a10;
        bus2.addr        = v.addr;
        bus2.ppu_data_i  = v.wdata;
        bus2.cart_data_i = v.cdata;
        @(posedge clk);
        #1;
        check({v.name, "_data"}, bus2.data_o, v.exp_d);
        check({v.name, "_rvalid"}, {7'd0, bus2.rvalid_o}, {7'd0, v.exp_v});
    endtask

    task automatic op4(input logic rd, input logic wr, input logic [2:0] mir,
                       input logic [13:0] addr, input logic [7:0] wdata);
        bus4.rd         = rd;
        bus4.wr         = wr;
        bus4.vram_cs    = 1'b1;
        bus4.mirror_i   = mir;
        bus4.addr       = addr;
        bus4.ppu_data_i = wdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] nt4_val [4];
        nt4_val = '{8'h11, 8'h22, 8'h33, 8'h44};

        // name, rd, wr, cs, mir, a10, addr, wdata, cdata, exp_d, exp_v
        vecs.push_back(mk("wr_2000_m1",   1, 0, 1, 3'd0, 0, 14'h0000, 8'h00, 8'h00, 8'h00, 0));
        vecs.delete();
        vecs.push_back(mk("wr_2000_m1",   0, 1, 1, 3'd1, 0, 14'h2000, 8'h5A, 8'h00, 8'h5A, 0));
        vecs.push_back(mk("rd_2800_m1",   1, 0, 1, 3'd1, 0, 14'h2800, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("wr_2400_m1",   0, 1, 1, 3'd1, 0, 14'h2400, 8'h00, 8'h00, 8'h00, 0));
        vecs.push_back(mk("rd_2400_m1",   1, 0, 1, 3'd1, 0, 14'h2400, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk("rd_2400_m0",   1, 0, 1, 3'd0, 0, 14'h2400, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("rd_2800_m0",   1, 0, 1, 3'd0, 0, 14'h2800, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk("rd_2c00_m2",   1, 0, 1, 3'd2, 0, 14'h2C00, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("rd_2000_m3",   1, 0, 1, 3'd3, 0, 14'h2000, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk("rd_2400_cart0",1, 0, 1, 3'd4, 0, 14'h2400, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("rd_2000_cart1",1, 0, 1, 3'd4, 1, 14'h2000, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk("rd_2c00_m5",   1, 0, 1, 3'd5, 0, 14'h2C00, 8'h00, 8'h00, 8'h00, 1));
        vecs.push_back(mk("rd_2800_m7",   1, 0, 1, 3'd7, 0, 14'h2800, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("wr_23ff_m1",   0, 1, 1, 3'd1, 0, 14'h23FF, 8'hE1, 8'h00, 8'hE1, 0));
        vecs.push_back(mk("rd_2bff_m1",   1, 0, 1, 3'd1, 0, 14'h2BFF, 8'h00, 8'h00, 8'hE1, 1));
        vecs.push_back(mk("rd_2000_low",  1, 0, 1, 3'd1, 0, 14'h2000, 8'h00, 8'h00, 8'h5A, 1));
        vecs.push_back(mk("rd_cart_c3",   1, 0, 0, 3'd1, 0, 14'h0123, 8'h00, 8'hC3, 8'hC3, 1));
        vecs.push_back(mk("idle_hold",    0, 0, 0, 3'd1, 0, 14'h0123, 8'h12, 8'h34, 8'hC3, 0));
        vecs.push_back(mk("rdwr_2005",    1, 1, 1, 3'd1, 0, 14'h2005, 8'h77, 8'h00, 8'h77, 0));
        vecs.push_back(mk("rd_cart_3c",   1, 0, 0, 3'd1, 0, 14'h2005, 8'h00, 8'h3C, 8'h3C, 1));
        vecs.push_back(mk("rd_2005",      1, 0, 1, 3'd1, 0, 14'h2005, 8'h00, 8'h00, 8'h77, 1));
        vecs.push_back(mk("wr_cart_2005", 0, 1, 0, 3'd1, 0, 14'h2005, 8'h99, 8'h00, 8'h99, 0));
        vecs.push_back(mk("rd_2005_kept", 1, 0, 1, 3'd1, 0, 14'h2005, 8'h00, 8'h00, 8'h77, 1));
        vecs.push_back(mk("wr_2123",      0, 1, 1, 3'd1, 0, 14'h2123, 8'hAB, 8'h00, 8'hAB, 0));
        vecs.push_back(mk("rd_2123_wf",   1, 0, 1, 3'd1, 0, 14'h2123, 8'h00, 8'h00, 8'hAB, 1));
        vecs.push_back(mk("rd_2923_b2b",  1, 0, 1, 3'd1, 0, 14'h2923, 8'h00, 8'h00, 8'hAB, 1));
        vecs.push_back(mk("idle_end",     0, 0, 1, 3'd1, 0, 14'h2923, 8'h00, 8'h00, 8'hAB, 0));

        rst = 1'b1;
        idle2();
        bus2.vram_cs = 1'b1; bus2.mirror_i = 3'd0; bus2.cart_a10 = 1'b0;
        bus2.addr = 14'h0; bus2.ppu_data_i = 8'h0; bus2.cart_data_i = 8'h0;
        bus4.rd = 1'b0; bus4.wr = 1'b0; bus4.vram_cs = 1'b1; bus4.mirror_i = 3'd0;
        bus4.cart_a10 = 1'b0; bus4.addr = 14'h0; bus4.ppu_data_i = 8'h0; bus4.cart_data_i = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data2", bus2.data_o, 8'h00);
        check("reset_rvalid2", {7'd0, bus2.rvalid_o}, 8'h00);
        check("reset_data4", bus4.data_o, 8'h00);
        rst = 1'b0;

        foreach (vecs[i]) apply2(vecs[i]);
        idle2();

        for (int k = 0; k < 4; k++) begin
            op4(1'b0, 1'b1, 3'd0, 14'h2000 + 14'(k * 'h400), nt4_val[k]);
            check($sformatf("nt4_wr_%0d", k), bus4.data_o, nt4_val[k]);
        end
        for (int m = 0; m < 8; m++) begin
            for (int k = 0; k < 4; k++) begin
                op4(1'b1, 1'b0, 3'(m), 14'h2000 + 14'(k * 'h400), 8'h00);
                check($sformatf("nt4_rd_m%0d_%0d", m, k), bus4.data_o, nt4_val[k]);
                check($sformatf("nt4_rv_m%0d_%0d", m, k), {7'd0, bus4.rvalid_o}, 8'h01);
            end
        end
        bus4.rd = 1'b0;

        apply2(mk("wr_ff", 0, 1, 0, 3'd1, 0, 14'h0000, 8'hFF, 8'h00, 8'hFF, 0));
        idle2();
`ifdef PPU_BUS_DECAY_EN
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("decay_hold_%0d", c), bus2.data_o, 8'hFF);
        end
        @(posedge clk);
        #1;
        check("decay_clear_16", bus2.data_o, 8'h00);
`else
        repeat (100) @(posedge clk);
        #1;
        check("no_decay_100", bus2.data_o, 8'hFF);
`endif

        apply2(mk("rst_pre_rd", 1, 0, 1, 3'd1, 0, 14'h2000, 8'h00, 8'h00, 8'h5A, 1));
        rst = 1'b1;
        apply2(mk("rst_mid_rd", 1, 0, 1, 3'd1, 0, 14'h2123, 8'h00, 8'h00, 8'h00, 0));
        apply2(mk("rst_wr_drop", 0, 1, 1, 3'd1, 0, 14'h2000, 8'hEE, 8'h00, 8'h00, 0));
        rst = 1'b0;
        apply2(mk("post_rst_rd", 1, 0, 1, 3'd1, 0, 14'h2000, 8'h00, 8'h00, 8'h5A, 1));
        apply2(mk("post_rst_rd2", 1, 0, 1, 3'd1, 0, 14'h2123, 8'h00, 8'h00, 8'hAB, 1));
        idle2();
        @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ppu_bus_ctrl.md
# ppu_bus_ctrl

Parametrised PPU-side bus controller. It replaces the fixed 2 KiB VRAM and output mux with a configurable nametable RAM (2 or 4 nametables) and an internal mirroring mapper selected at run time. It adds a handshaked one-cycle read path and an open-bus data latch that can decay. It sits between the PPU core's address/data port and the cartridge CHR/CIRAM interface.

## Interface
Parameters:
- `NT_BITS`, 10: address bits per nametable (1 KiB).
- `NT_COUNT`, 2: physical nametables (2 or 4); VRAM depth is `NT_COUNT * 2**NT_BITS`.
- `DECAY_CYCLES`, 1_000_000: idle cycles before open-bus latch clears (used only with decay compiled in).

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, synchronous, active-high.
- `addr` in 14: PPU bus address.
- `rd` in 1: read request, one cycle per access.
- `wr` in 1: write request, one cycle per access.
- `vram_cs` in 1: cartridge CIRAM enable; access targets internal VRAM.
- `mirror_i` in 3: mirroring mode.
- `cart_a10` in 1: cartridge-driven bank bit, used in mode 4.
- `ppu_data_i` in 8: write data from PPU.
- `cart_data_i` in 8: cartridge read data.
- `data_o` out 8: bus latch value.
- `rvalid_o` out 1: pulses one cycle when `data_o` holds fresh read data.

## Operation
- Bank select, when `NT_COUNT==2`:
  - `mirror_i` 0 (horizontal) → `addr[11]`.
  - 1 (vertical) → `addr[10]`.
  - 2 (single low) → 0.
  - 3 (single high) → 1.
  - 4 (cart) → `cart_a10`.
  - 5–7 → same as 1.
- Bank select, when `NT_COUNT==4`: bank = `addr[11:10]`, and `mirror_i` is ignored.
- VRAM index = `{bank, addr[NT_BITS-1:0]}`.
- Write (`wr`=1): if `vram_cs`, VRAM[index] ← `ppu_data_i` at the edge. The latch ← `ppu_data_i` regardless of `vram_cs`. `rvalid_o` stays 0.
- Read (`rd`=1, `wr`=0): latch ← VRAM[index] if `vram_cs`, else `cart_data_i`. `rvalid_o`=1 the next cycle.
- `rd` and `wr` both high: treated as a write only.
- Idle (`rd`=`wr`=0): latch holds. `rvalid_o`=0.
- `data_o` is the latch output directly.

## Timing
- Reset: `data_o`=0, `rvalid_o`=0, decay counter=0. VRAM contents are untouched.
- Read latency is 1: request at edge N, data on `data_o` and `rvalid_o`=1 after edge N+1... i.e. in the cycle following the request.
- Back-to-back reads are allowed every cycle, and `rvalid_o` stays high continuously.
- A read in cycle N+1 of the address written in cycle N returns the new data (write-first array behaviour).
- A mid-access reset discards the pending `rvalid_o`. A write committed on the same edge as `rst` is ignored.
- Decay counter (macro on):
  - Clears on any `rd` or `wr`.
  - Otherwise increments, saturating at `DECAY_CYCLES`.
  - On the cycle it reaches `DECAY_CYCLES`, the latch ← 0.
  - Counter width is `$clog2(DECAY_CYCLES+1)`.

## Configuration
- `PPU_BUS_DECAY_EN` defined: the open-bus latch decays to 0 after `DECAY_CYCLES` idle cycles, as above.
- Not defined: no counter is built, and the latch holds its last value indefinitely.

## Structure
- Package `ppu_bus_pkg`:
  - `mirror_e` enum (`MIR_H`=0, `MIR_V`, `MIR_SINGLE_LO`, `MIR_SINGLE_HI`, `MIR_CART`).
  - Default `NT_BITS`.
- Sub-module `ppu_nt_map`: combinational `addr`/`mirror_i`/`cart_a10` → VRAM index.
- Top level holds the RAM array, the latch, `rvalid_o` and the decay counter.

## Test plan
- Mirroring, mode 1: write 0x5A at 0x2000, read 0x2800 → 0x5A. Read 0x2400 → not 0x5A (after clearing). Mode 0: read 0x2400 → 0x5A.
- `NT_COUNT=4`: write 0x11/0x22/0x33/0x44 at 0x2000/0x2400/0x2800/0x2C00. Reading each back returns a distinct value for every `mirror_i`.
- Cart read: `vram_cs`=0, `cart_data_i`=0xC3, pulse `rd` → `data_o`=0xC3 and `rvalid_o`=1 exactly one cycle later. Idle → `data_o` holds and `rvalid_o`=0.
- Simultaneous `rd`+`wr` of 0x77 at 0x2005 → `rvalid_o` stays 0 and `data_o`=0x77. A following read of 0x2005 returns 0x77.
- Decay (`PPU_BUS_DECAY_EN`, `DECAY_CYCLES`=16): write 0xFF, then idle. `data_o`=0xFF through 15 idle cycles, and 0x00 after the 16th. Without the macro, `data_o` is still 0xFF after 100 cycles.
- Reset asserted the cycle after a read request → `rvalid_o`=0 and `data_o`=0. A previously written VRAM byte reads back unchanged after reset.
